prog_cntr_unit: RTL

//   Fetch-stage program counter register plus hardware return-address stack.

---
 rtl/prog_cntr_unit_if.sv | 34 +++
 rtl/prog_cntr_unit.sv | 94 +++++++++
 2 files changed

// File: rtl/prog_cntr_unit_if.sv
// Fetch-stage PC / return-stack signal bundle.
// master drives the control side; slave (the PC unit) drives the PC and stack outputs.
interface prog_cntr_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned STACK_DEPTH = 8
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);

  logic                  stall;
  logic [ADDR_WIDTH-1:0] prog_cntr_load_val;
  logic                  call_push;
  logic                  int_push;
  logic                  ret_pop;
  logic [ADDR_WIDTH-1:0] prog_cntr;
  logic [ADDR_WIDTH-1:0] next_prog_cntr;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [DW-1:0]         stack_depth;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  stack_ovf;
  logic                  stack_unf;

  modport master (
    output stall, prog_cntr_load_val, call_push, int_push, ret_pop,
    input  prog_cntr, next_prog_cntr, ret_addr, stack_depth,
           stack_empty, stack_full, stack_ovf, stack_unf
  );

  modport slave (
    input  stall, prog_cntr_load_val, call_push, int_push, ret_pop,
    output prog_cntr, next_prog_cntr, ret_addr, stack_depth,
           stack_empty, stack_full, stack_ovf, stack_unf
  );
endinterface

// File: rtl/prog_cntr_unit.sv
// Fetch-stage program counter register plus hardware return-address stack.
// Calls and interrupt entry push a return address; returns pop it.
module prog_cntr_unit #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input logic             clock,
  input logic             reset,
  prog_cntr_unit_if.slave bus
);
  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW = $clog2(STACK_DEPTH);
  localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [ADDR_WIDTH-1:0] entry [STACK_DEPTH];
  logic [DW-1:0]         depth_q, depth_nxt;
  logic                  ovf_q, unf_q, ovf_set, unf_set;
  logic                  empty, full;
  logic                  do_push, do_pop;
  logic [ADDR_WIDTH-1:0] push_val;
  logic [IW-1:0]         top_idx;
  logic                  wr_en;
  logic [IW-1:0]         wr_idx;

  assign pc_plus1 = pc_q + ADDR_WIDTH'(1);
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == FULL_CNT);
  assign top_idx  = IW'(depth_q - DW'(1));
  assign do_push  = !bus.stall && (bus.int_push || bus.call_push);
  assign do_pop   = !bus.stall && bus.ret_pop;
  // Interrupt entry returns to the interrupted instruction, CALL to the one after.
  assign push_val = bus.int_push ? pc_q : pc_plus1;

  // Stack bookkeeping: decide entry write, depth update and flag setting.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = top_idx;
    depth_nxt = depth_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (do_push && do_pop) begin
      wr_en = 1'b1;
      // Replace-top on a non-empty stack; on an empty one it degrades to a push.
      if (empty) begin
        wr_idx    = '0;
        depth_nxt = DW'(1);
        unf_set   = 1'b1;
      end
    end else if (do_push) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en     = 1'b1;
        wr_idx    = IW'(depth_q);
        depth_nxt = depth_q + DW'(1);
      end
    end else if (do_pop) begin
      if (empty) unf_set = 1'b1;
      else       depth_nxt = depth_q - DW'(1);
    end
  end

  // PC register, stack depth and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!bus.stall) begin
      pc_q    <= bus.prog_cntr_load_val;
      depth_q <= depth_nxt;
      ovf_q   <= ovf_q | ovf_set;
      unf_q   <= unf_q | unf_set;
    end
  end

  // Stack storage; contents survive reset, only depth is cleared.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) entry[wr_idx] <= push_val;
  end

  assign bus.prog_cntr      = pc_q;
  assign bus.next_prog_cntr = pc_plus1;
  assign bus.ret_addr       = empty ? '0 : entry[top_idx];
  assign bus.stack_depth    = depth_q;
  assign bus.stack_empty    = empty;
  assign bus.stack_full     = full;
  assign bus.stack_ovf      = ovf_q;
  assign bus.stack_unf      = unf_q;
endmodule
